// File: rtl/ahb_master_arb.sv
// Purpose : round-robin arbiter sharing one AHB-Lite master port among N req/ack clients,
//           issuing one non-pipelined SINGLE transfer at a time; misaligned requests never reach the bus.
// Latency : req sampled in IDLE at k -> address phase k+1, data phase k+2, ack k+3 (+1 per hready=0 cycle);
//           misaligned request -> ack with err at k+1.
// Backpressure: losing clients hold req until their ack; hready=0 stretches the address or data phase.
// Ports   : hclk/hreset clock and async active-high reset;
//           req/we/addr/wdata/size per-client request fields (addr/wdata packed 32 bits per client, size 3);
//           ack/err/rdata completion to the owning client; grant one-hot current owner;
//           haddr/hwdata/hwrite/htrans/hsize/hburst/hsel/hrdata/hresp/hready AHB-Lite master port.
module ahb_master_arb #(
  parameter int N = 2
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [32*N-1:0] addr,
  input  logic [32*N-1:0] wdata,
  input  logic [3*N-1:0]  size,
  output logic [N-1:0]    ack,
  output logic            err,
  output logic [31:0]     rdata,
  output logic [N-1:0]    grant,
  output logic [31:0]     haddr,
  output logic [31:0]     hwdata,
  output logic            hwrite,
  output logic [1:0]      htrans,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic            hsel,
  input  logic [31:0]     hrdata,
  input  logic [1:0]      hresp,
  input  logic            hready
);

  localparam int         IW            = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   haddr_q, haddr_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hwrite_q, hwrite_d;
  logic [1:0]    htrans_q, htrans_d;
  logic [2:0]    hsize_q, hsize_d;
  logic          hsel_q, hsel_d;

  // Arbitration and winner field selection
  logic [N-1:0]  req_m;
  logic [N-1:0]  cand_oh;
  int            cand;
  logic          found;
  logic [IW-1:0] win;
  logic [N-1:0]  win_oh;
  logic          win_we;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic [2:0]    win_size;
  logic          win_aligned;

  always_comb begin
    // A client being acked this cycle has already been served; never re-grant it on the same edge.
    req_m   = req & ~ack_q;
    found   = 1'b0;
    win     = '0;
    cand    = 0;
    cand_oh = '0;
    // Search order starts one past the previous owner and wraps.
    for (int off = 1; off <= N; off++) begin
      cand    = (int'(last_q) + off) % N;
      cand_oh = {{(N-1){1'b0}}, 1'b1} << cand;
      if (!found && (|(req_m & cand_oh))) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
    win_oh = {{(N-1){1'b0}}, 1'b1} << win;

    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_size  = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(win) == i) begin
        win_we    = we[i];
        win_addr  = addr[32*i +: 32];
        win_wdata = wdata[32*i +: 32];
        win_size  = size[3*i +: 3];
      end
    end

    win_aligned = (win_size == 3'd0) ||
                  ((win_size == 3'd1) && !win_addr[0]) ||
                  ((win_size == 3'd2) && (win_addr[1:0] == 2'b00));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    hsel_d   = hsel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = win;
          grant_d = win_oh;
          if (win_aligned) begin
            state_d  = ST_ADDR;
            haddr_d  = win_addr;
            hwrite_d = win_we;
            hsize_d  = win_size;
            wdata_d  = win_wdata;
            htrans_d = HTRANS_NONSEQ;
            hsel_d   = 1'b1;
          end else begin
            // Misaligned: complete with error straight away, bus stays IDLE.
            state_d = ST_RESP;
            err_d   = 1'b1;
            ack_d   = win_oh;
          end
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hsel_d   = 1'b0;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        // hresp only counts on the hready=1 cycle; the first cycle of a two-cycle ERROR is a wait.
        if (hready) begin
          state_d = ST_RESP;
          rdata_d = hrdata;
          err_d   = (hresp == HRESP_ERROR);
          ack_d   = grant_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(N-1);
      owner_q  <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= '0;
      hsel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      hsel_q   <= hsel_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign grant  = grant_q;
  assign haddr  = haddr_q;
  assign hwdata = hwdata_q;
  assign hwrite = hwrite_q;
  assign htrans = htrans_q;
  assign hsize  = hsize_q;
  assign hsel   = hsel_q;
  assign hburst = 3'b000;

endmodule

// File: tb/tb_ahb_master_arb.sv
// Bench for ahb_master_arb: directed scenarios plus randomized clients and slave,
// checked cycle by cycle against a transaction-level timing model.
module tb_ahb_master_arb;
  localparam int N = 2;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [N-1:0]    req, we, ack, grant;
  logic [32*N-1:0] addr, wdata;
  logic [3*N-1:0]  size;
  logic            err, hwrite, hsel, hready;
  logic [31:0]     rdata, haddr, hwdata, hrdata;
  logic [1:0]      htrans, hresp;
  logic [2:0]      hsize, hburst;

  always #5 hclk = ~hclk;

  ahb_master_arb #(.N(N)) dut (
    .hclk(hclk), .hreset(hreset),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size),
    .ack(ack), .err(err), .rdata(rdata), .grant(grant),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hsel(hsel),
    .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Client-side request state
  bit          c_req[N];
  bit          c_we[N];
  logic [31:0] c_addr[N];
  logic [31:0] c_wdata[N];
  logic [2:0]  c_size[N];

  // Transaction model: one transfer in flight, described by its phase boundary cycles
  int          cyc, next_idle, last_g, owner;
  int          t_dec, t_addr1, t_data1, t_ack;
  bit          active, mis, e_we, e_err, perr;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [2:0]  e_size;

  // Stimulus knobs
  int          raise_pct;
  bit          allow_mis, force_plan, f_err;
  int          f_aw, f_dw;
  logic [31:0] f_rd;

  int          k, a;
  int          ack_at[$];
  int          ack_who[$];

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  function automatic bit misaligned(input logic [2:0] s, input logic [31:0] ad);
    return (s > 3'd2) || (s == 3'd1 && ad % 2 != 0) || (s == 3'd2 && ad % 4 != 0);
  endfunction

  task automatic set_client(input int i, input bit w, input logic [31:0] ad,
                            input logic [31:0] d, input logic [2:0] s);
    c_req[i] = 1'b1; c_we[i] = w; c_addr[i] = ad; c_wdata[i] = d; c_size[i] = s;
  endtask

  task automatic drive_clients();
    for (int i = 0; i < N; i++) begin
      req[i]              = c_req[i];
      we[i]               = c_we[i];
      addr[32*i +: 32]    = c_addr[i];
      wdata[32*i +: 32]   = c_wdata[i];
      size[3*i +: 3]      = c_size[i];
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_hsel", 32'(hsel), 32'd0);
  endtask

  task automatic check_outputs();
    bit at_ack, in_addr, in_data;
    at_ack  = active && cyc == t_ack;
    in_addr = active && !mis && cyc > t_dec && cyc <= t_addr1;
    in_data = active && !mis && cyc > t_addr1 && cyc <= t_data1;
    chk("ack", 32'(ack), at_ack ? 32'(oh(owner)) : 32'd0);
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    if (at_ack) begin
      chk("err", 32'(err), 32'(e_err));
      if (!e_we && !mis) chk("rdata", rdata, e_rd);
    end
    chk("htrans", 32'(htrans), in_addr ? 32'd2 : 32'd0);
    chk("hsel", 32'(hsel), 32'(in_addr));
    if (in_addr) begin
      chk("haddr", haddr, e_addr);
      chk("hwrite", 32'(hwrite), 32'(e_we));
      chk("hsize", 32'(hsize), 32'(e_size));
    end
    if (in_data) chk("hwdata", hwdata, e_wdata);
    chk("grant", 32'(grant), (active && cyc > t_dec && cyc <= t_ack) ? 32'(oh(owner)) : 32'd0);
    chk("hburst", 32'(hburst), 32'd0);
    if (at_ack) begin
      c_req[owner] = 1'b0;
      last_g       = owner;
      active       = 1'b0;
      next_idle    = cyc + 1;
    end
  endtask

  task automatic drive_cycle();
    int w, aw, dw;
    logic [2:0]  s;
    logic [31:0] ad;
    for (int i = 0; i < N; i++) begin
      if (!c_req[i] && $urandom_range(1, 100) <= raise_pct) begin
        s  = (allow_mis && $urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        ad = $urandom;
        if (!allow_mis || $urandom_range(0, 3) != 0) begin
          if (s == 3'd1) ad[0] = 1'b0;
          if (s == 3'd2) ad[1:0] = 2'b00;
        end
        set_client(i, 1'($urandom_range(0, 1)), ad, $urandom, s);
      end
    end

    // Round-robin decision when the arbiter is idle this cycle
    if (!active && cyc >= next_idle) begin
      w = -1;
      for (int o = 1; o <= N; o++) begin
        if (w < 0 && c_req[(last_g + o) % N]) w = (last_g + o) % N;
      end
      if (w >= 0) begin
        active  = 1'b1;
        owner   = w;
        t_dec   = cyc;
        e_we    = c_we[w];
        e_addr  = c_addr[w];
        e_wdata = c_wdata[w];
        e_size  = c_size[w];
        mis     = misaligned(e_size, e_addr);
        if (force_plan) begin
          aw = f_aw; dw = f_dw; perr = f_err; e_rd = f_rd;
        end else begin
          aw = $urandom_range(0, 2); dw = $urandom_range(0, 3);
          perr = ($urandom_range(0, 5) == 0); e_rd = $urandom;
        end
        if (mis) begin
          t_addr1 = cyc; t_data1 = cyc; t_ack = cyc + 1; e_err = 1'b1;
        end else begin
          t_addr1 = cyc + 1 + aw;
          t_data1 = t_addr1 + 1 + dw;
          t_ack   = t_data1 + 1;
          e_err   = perr;
        end
      end
    end

    // Slave: random junk outside the transfer's phases
    hready = 1'($urandom_range(0, 1));
    hresp  = 2'($urandom_range(0, 1));
    hrdata = $urandom;
    if (active && !mis && cyc > t_dec && cyc <= t_addr1) begin
      hready = (cyc == t_addr1);
      hresp  = 2'b00;
    end else if (active && !mis && cyc > t_addr1 && cyc <= t_data1) begin
      hready = (cyc == t_data1);
      if (perr) hresp = (cyc >= t_data1 - 1) ? 2'b01 : 2'b00;
      else if (cyc == t_data1) hresp = 2'b00;
      if (cyc == t_data1) hrdata = e_rd;
    end
    drive_clients();
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
    cyc++;
    check_outputs();
    drive_cycle();
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 60 && at < 0; i++) begin
      step();
      if (ack != '0) at = cyc;
    end
    if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit busy;
    busy = 1'b1;
    for (int i = 0; i < 300 && busy; i++) begin
      step();
      busy = active;
      for (int j = 0; j < N; j++) if (c_req[j]) busy = 1'b1;
    end
    if (busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    hreset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; size = '0;
    hrdata = '0; hresp = '0; hready = 1'b1;
    for (int i = 0; i < N; i++) begin
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0; c_size[i] = '0;
    end
    cyc = 0; next_idle = 0; last_g = N - 1; owner = 0; active = 1'b0; mis = 1'b0;
    t_dec = 0; t_addr1 = 0; t_data1 = 0; t_ack = 0;
    e_we = 0; e_err = 0; perr = 0; e_addr = '0; e_wdata = '0; e_rd = '0; e_size = '0;
    raise_pct = 0; allow_mis = 1'b0; force_plan = 1'b1;
    f_aw = 0; f_dw = 0; f_err = 1'b0; f_rd = 32'h1357_9BDF;

    repeat (3) @(posedge hclk);
    #1;
    check_reset_outputs();

    // Both clients request continuously from reset
    set_client(0, 1'b0, 32'h0000_0100, 32'h0, 3'd2);
    set_client(1, 1'b1, 32'h0000_0200, 32'h0000_55AA, 3'd2);
    raise_pct = 100;
    hreset = 1'b0;
    drive_cycle();
    for (int i = 0; i < 40 && ack_at.size() < 4; i++) begin
      step();
      if (ack != '0) begin
        ack_at.push_back(cyc);
        ack_who.push_back(ack[1] ? 1 : 0);
      end
    end
    chk("cont_count", 32'(ack_at.size()), 32'd4);
    if (ack_at.size() > 0) chk("cont_first", 32'(ack_at[0]), 32'd3);
    for (int i = 0; i < ack_at.size(); i++) begin
      chk("cont_order", 32'(ack_who[i]), 32'(i % 2));
      if (i > 0) chk("cont_gap", 32'(ack_at[i] - ack_at[i-1]), 32'd4);
    end
    raise_pct = 0;
    drain();

    // Word read, zero-wait slave
    f_aw = 0; f_dw = 0; f_err = 1'b0; f_rd = 32'hDEAD_BEEF;
    set_client(0, 1'b0, 32'h0000_0010, 32'h0, 3'd2);
    step(); k = cyc;
    step();
    chk("t1_htrans", 32'(htrans), 32'd2);
    chk("t1_haddr", haddr, 32'h0000_0010);
    chk("t1_hsize", 32'(hsize), 32'd2);
    wait_ack(a);
    chk("t1_lat", 32'(a - k), 32'd3);
    chk("t1_ack", 32'(ack), 32'b01);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(err), 32'd0);

    // Client 1 halfword write, two data-phase wait states
    f_dw = 2;
    set_client(1, 1'b1, 32'h0000_0022, 32'h0000_1234, 3'd1);
    step(); k = cyc;
    wait_ack(a);
    chk("t2_lat", 32'(a - k), 32'd5);
    chk("t2_ack", 32'(ack), 32'b10);
    chk("t2_err", 32'(err), 32'd0);

    // Two-cycle slave ERROR, then a normal read
    f_dw = 1; f_err = 1'b1; f_rd = 32'h0BAD_0BAD;
    set_client(0, 1'b0, 32'h0000_0080, 32'h0, 3'd2);
    step(); k = cyc;
    wait_ack(a);
    chk("t3_lat", 32'(a - k), 32'd4);
    chk("t3_err", 32'(err), 32'd1);
    f_dw = 0; f_err = 1'b0; f_rd = 32'h8765_4321;
    set_client(0, 1'b0, 32'h0000_0084, 32'h0, 3'd2);
    step(); k = cyc;
    wait_ack(a);
    chk("t3b_lat", 32'(a - k), 32'd3);
    chk("t3b_err", 32'(err), 32'd0);
    chk("t3b_rdata", rdata, 32'h8765_4321);

    // Misaligned word read never reaches the bus
    set_client(0, 1'b0, 32'h0000_0002, 32'h0, 3'd2);
    step(); k = cyc;
    wait_ack(a);
    chk("t4_lat", 32'(a - k), 32'd1);
    chk("t4_ack", 32'(ack), 32'b01);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_htrans", 32'(htrans), 32'd0);

    // Randomized traffic
    force_plan = 1'b0; allow_mis = 1'b1; raise_pct = 35;
    repeat (3000) step();
    raise_pct = 0;
    drain();

    // Reset during a data-phase wait
    force_plan = 1'b1; allow_mis = 1'b0;
    f_aw = 0; f_dw = 0; f_err = 1'b0; f_rd = 32'hCAFE_0001;
    set_client(0, 1'b0, 32'h0000_0040, 32'hA5A5_A5A5, 3'd2);
    step();
    wait_ack(a);
    f_dw = 3;
    set_client(0, 1'b0, 32'h0000_0044, 32'hA5A5_A5A5, 3'd2);
    step();
    repeat (3) step();
    chk("t6_in_data", 32'(hready), 32'd0);
    hreset = 1'b1;
    #1;
    check_reset_outputs();
    active = 1'b0; last_g = N - 1;
    for (int i = 0; i < N; i++) c_req[i] = 1'b0;
    drive_clients();
    repeat (2) begin
      @(posedge hclk);
      #1;
      cyc++;
      chk("t6_noack", 32'(ack), 32'd0);
    end
    f_dw = 0;
    set_client(0, 1'b0, 32'h0000_0050, 32'h0, 3'd2);
    set_client(1, 1'b0, 32'h0000_0060, 32'h0, 3'd2);
    hreset = 1'b0;
    next_idle = cyc;
    drive_cycle();
    step();
    chk("t6_rr_grant", 32'(grant), 32'b01);
    wait_ack(a);
    chk("t6_ack", 32'(ack), 32'b01);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_arb.md
# ahb_master_arb

Round-robin arbiter and transfer sequencer that shares one AHB-Lite master port (haddr/hwdata/hrdata/hwrite/htrans/hsize/hburst/hresp/hready/hsel) between N simple request/acknowledge clients, such as the UART testbench driver and a register-init engine. It issues one non-pipelined SINGLE transfer at a time and returns read data and error status to the owning client. It also rejects misaligned requests without touching the bus.

## Interface
- N, 2, number of requesters (2..8)
- hclk  in  1  bus clock; all logic on rising edge
- hreset  in  1  asynchronous, active-high reset
- req  in  N  per-client request level; must be held until that client's ack
- we  in  N  per-client write (1) / read (0)
- addr  in  32*N  per-client byte address; client i uses bits [32*i+31:32*i]
- wdata  in  32*N  per-client write data, same packing
- size  in  3*N  per-client hsize encoding: 0 byte, 1 half, 2 word
- ack  out  N  one-cycle completion pulse to the owning client
- err  out  1  valid with ack: transfer failed (bus ERROR or misaligned)
- rdata  out  32  valid with ack on reads: captured hrdata
- grant  out  N  one-hot current owner; 0 when idle
- haddr  out  32  AHB address
- hwdata  out  32  AHB write data
- hwrite  out  1  AHB write
- htrans  out  2  AHB transfer type: IDLE 2'b00, NONSEQ 2'b10 only
- hsize  out  3  AHB size
- hburst  out  3  constant 3'b000 (SINGLE)
- hsel  out  1  high during address phase only
- hrdata  in  32  AHB read data
- hresp  in  2  AHB response; 2'b01 is ERROR
- hready  in  1  AHB ready

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Arbitrate among req bits, excluding any client whose ack is high this cycle.
  - Round-robin: search starts at last_grant+1 and wraps modulo N; last_grant resets to N-1, so client 0 wins first.
  - On a winner, register its we/addr/wdata/size and set grant.
  - Aligned request (size≤2; size 1 needs addr[0]=0; size 2 needs addr[1:0]=0): go to ADDR.
  - Otherwise go to RESP with err=1. No bus access occurs.
- ADDR:
  - Drive htrans=NONSEQ, hsel=1, and the registered haddr/hwrite/hsize.
  - hready=1: go to DATA. hready=0: hold all address signals.
- DATA:
  - Drive htrans=IDLE and hsel=0. hwdata holds the registered wdata for the whole phase, on reads too.
  - hready=1: capture hrdata into rdata and hresp==2'b01 into err, then go to RESP.
  - hresp is sampled only when hready=1. The first ERROR cycle (hready=0) is a wait.
- RESP:
  - ack[owner]=1 for exactly one cycle; err and rdata are valid.
  - Update last_grant to owner, clear grant, go to IDLE.
  - rdata and err hold until the next RESP.
- At most one ack bit is high in any cycle. A req bit dropped before its ack is a protocol violation; the block's behaviour in that case is unspecified.
- Reset (asynchronous, any state):
  - Outputs: ack=0, err=0, rdata=0, grant=0, haddr=0, hwdata=0, hwrite=0, htrans=2'b00, hsize=0, hburst=0, hsel=0.
  - State: IDLE, last_grant=N-1.
  - An in-flight transfer is dropped with no ack.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Request sampled in IDLE at cycle k:
  - k+1: address phase.
  - k+2: data phase, with a zero-wait slave.
  - k+3: ack.
  - Each hready=0 cycle in ADDR or DATA adds one cycle.
- Misaligned request sampled at k: ack with err=1 at k+1; htrans stays IDLE.
- The RESP cycle is followed by IDLE. The next address phase is no earlier than ack+2. Peak rate is one transfer per 4 cycles.
- Simultaneous requests: exactly one is granted per IDLE decision; the others wait with req held. With N clients all requesting continuously, each client is served once every N transfers.

## Test plan
- Single word read by client 0, addr 32'h0000_0010, zero-wait slave returning 32'hDEAD_BEEF:
  - k+1: htrans=2'b10, haddr=32'h10, hsize=2.
  - k+3: ack=2'b01, rdata=32'hDEAD_BEEF, err=0.
- Client 1 halfword write, addr 32'h0000_0022, wdata 32'h0000_1234, slave inserts 2 wait states in data phase:
  - hwdata=32'h0000_1234 held for 3 cycles.
  - ack=2'b10 at k+5.
- Both clients request continuously from reset:
  - Grant order 0,1,0,1.
  - Acks exactly 4 cycles apart.
  - No cycle with both ack bits high.
- Slave ERROR (hready 0/hresp 01, then hready 1/hresp 01) on client 0 read: ack with err=1, then the next transfer proceeds normally.
- Client 0 word read at addr 32'h0000_0002: htrans stays 2'b00 throughout; ack=2'b01 with err=1 at k+1.
- hreset asserted during DATA wait: all outputs return to reset values in the same cycle, no ack pulse, and a new request after release is granted to client 0.
